// File: rtl/pe_fetch_unit.sv
// pe_fetch_unit: per-PE instruction fetch front end for the 4-PE CGRA.
// Each lane keeps its own PC and drives one read port of the shared
// instruction memory. The memory returns the word one cycle after the read.
// That word goes to the PE decode stage over a valid/ready handshake.
// A 1-entry skid buffer per lane absorbs backpressure.
//
// Ports (lane i of each flattened bus is at [i*XLEN +: XLEN]):
//   clk, rst            clock, synchronous active-high reset
//   start               per-lane pulse: IDLE/HALT -> RUN at RESET_PC
//   halt_req            per-lane stop request (flushes the lane)
//   redirect_valid/pc   per-lane branch/jump target
//   imem_read_enable    read strobe to instruction memory
//   imem_pc             word-index read address to instruction memory
//   imem_instruction    registered read data from instruction memory
//   instr_valid/ready   handshake to PE decode
//   instr, instr_pc     instruction word and its PC
//   running             lane FSM is in RUN
//   fetch_fault         sticky: lane tried to fetch at pc >= IMEM_DEPTH

module pe_fetch_lane #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 256,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt_req,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            read_enable,
    output logic [XLEN-1:0] fetch_pc,
    input  logic [XLEN-1:0] mem_word,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            running,
    output logic            fetch_fault
);
    localparam logic [XLEN-1:0] DEPTH = XLEN'(IMEM_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, inflight_pc_q, hold_instr, hold_pc;
    logic            inflight_q, squash_q, hold_valid, fault_q;

    logic run, flush, out_of_range, issue, start_ok, mem_live;

    assign run          = (state_q == RUN);
    // Redirect and halt both throw away whatever is in flight or held.
    assign flush        = run & (redirect_valid | halt_req);
    assign out_of_range = run & ~redirect_valid & (pc_q >= DEPTH);
    assign start_ok     = start & ~run;
    // The word returning this cycle is live unless a flush squashed it.
    assign mem_live     = inflight_q & ~squash_q;
    // A new read is allowed only if its return slot will be free next cycle.
    // That holds when nothing is in flight, the in-flight word is squashed,
    // or the PE consumes the in-flight word this cycle.
    assign issue = run & ~redirect_valid & ~halt_req & ~hold_valid &
                   (~inflight_q | squash_q | instr_ready) & (pc_q < DEPTH);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (halt_req | out_of_range) state_d = HALT;
            HALT:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            squash_q      <= 1'b0;
            hold_valid    <= 1'b0;
            hold_instr    <= '0;
            hold_pc       <= '0;
            fault_q       <= 1'b0;
        end else begin
            inflight_q <= issue;
            squash_q   <= flush;
            if (issue) inflight_pc_q <= pc_q;

            if (start_ok)                  pc_q <= RESET_PC;
            else if (run & redirect_valid) pc_q <= redirect_pc;
            else if (issue)                pc_q <= pc_q + XLEN'(1);

            if (flush) begin
                hold_valid <= 1'b0;
            end else if (hold_valid) begin
                if (instr_ready) hold_valid <= 1'b0;
            end else if (mem_live & ~instr_ready) begin
                hold_valid <= 1'b1;
                hold_instr <= mem_word;
                hold_pc    <= inflight_pc_q;
            end

            if (start_ok)          fault_q <= 1'b0;
            else if (out_of_range) fault_q <= 1'b1;
        end
    end

    assign read_enable = issue;
    assign fetch_pc    = issue ? pc_q : '0;
    assign instr_valid = ~flush & (hold_valid | mem_live);
    assign instr       = ~instr_valid ? '0 : (hold_valid ? hold_instr : mem_word);
    assign instr_pc    = ~instr_valid ? '0 : (hold_valid ? hold_pc : inflight_pc_q);
    assign running     = run;
    assign fetch_fault = fault_q;
endmodule

module pe_fetch_unit #(
    parameter int NUM_PE     = 4,
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int RESET_PC   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PE-1:0]      start,
    input  logic [NUM_PE-1:0]      halt_req,
    input  logic [NUM_PE-1:0]      redirect_valid,
    input  logic [NUM_PE*XLEN-1:0] redirect_pc,
    output logic [NUM_PE-1:0]      imem_read_enable,
    output logic [NUM_PE*XLEN-1:0] imem_pc,
    input  logic [NUM_PE*XLEN-1:0] imem_instruction,
    output logic [NUM_PE-1:0]      instr_valid,
    input  logic [NUM_PE-1:0]      instr_ready,
    output logic [NUM_PE*XLEN-1:0] instr,
    output logic [NUM_PE*XLEN-1:0] instr_pc,
    output logic [NUM_PE-1:0]      running,
    output logic [NUM_PE-1:0]      fetch_fault
);
    for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
        pe_fetch_lane #(
            .XLEN       (XLEN),
            .IMEM_DEPTH (IMEM_DEPTH),
            .RESET_PC   (XLEN'(RESET_PC))
        ) u_lane (
            .clk            (clk),
            .rst            (rst),
            .start          (start[g]),
            .halt_req       (halt_req[g]),
            .redirect_valid (redirect_valid[g]),
            .redirect_pc    (redirect_pc[g*XLEN +: XLEN]),
            .read_enable    (imem_read_enable[g]),
            .fetch_pc       (imem_pc[g*XLEN +: XLEN]),
            .mem_word       (imem_instruction[g*XLEN +: XLEN]),
            .instr_valid    (instr_valid[g]),
            .instr_ready    (instr_ready[g]),
            .instr          (instr[g*XLEN +: XLEN]),
            .instr_pc       (instr_pc[g*XLEN +: XLEN]),
            .running        (running[g]),
            .fetch_fault    (fetch_fault[g])
        );
    end
endmodule

// File: tb/tb_pe_fetch_unit.sv
// Bench for pe_fetch_unit: directed scenarios with exact cycle timing, then
// randomized traffic checked against a program-order reference model
// (each lane must deliver consecutive PCs from its last start/redirect target).
module tb_pe_fetch_unit;
    localparam int N = 4;
    localparam int W = 32;
    localparam logic [W-1:0] BASE = 32'hA000_0000;

    logic           clk = 1'b0, rst = 1'b1;
    logic [N-1:0]   start = '0, halt_req = '0, redirect_valid = '0, instr_ready = '1;
    logic [N*W-1:0] redirect_pc = '0, imem_instruction = '0;
    logic [N-1:0]   imem_read_enable, instr_valid, running, fetch_fault;
    logic [N*W-1:0] imem_pc, instr, instr_pc;

    int n_chk = 0, n_err = 0;

    pe_fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_read_enable(imem_read_enable), .imem_pc(imem_pc),
        .imem_instruction(imem_instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .running(running), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // Instruction memory: word k holds BASE+k, registered read per port.
    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (imem_read_enable[i])
                imem_instruction[i*W +: W] <= BASE + imem_pc[i*W +: W];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ln(input logic [N*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        start = '0; halt_req = '0; redirect_valid = '0; redirect_pc = '0;
        instr_ready = '1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_re"}, imem_read_enable, 0);
        chk({tag, "_ipc"}, imem_pc, 0);
        chk({tag, "_vld"}, instr_valid, 0);
        chk({tag, "_ins"}, instr, 0);
        chk({tag, "_ipcout"}, instr_pc, 0);
        chk({tag, "_run"}, running, 0);
        chk({tag, "_flt"}, fetch_fault, 0);
    endtask

    int          exp_pc[N];
    int          ndel[N];
    bit          mrun[N];
    bit          rv[N], hr[N], st[N];
    logic [W-1:0] rpc[N];

    initial begin
        // ---- 1: reset, then start lane 0 ----
        do_reset();
        start = 4'b0001;
        #1 chk_idle_outputs("rst");
        @(negedge clk) start = '0;
        #1;
        chk("t1_run", running, 4'b0001);
        chk("t1_re0", imem_read_enable, 4'b0001);
        chk("t1_pc0", ln(imem_pc, 0), 0);
        chk("t1_vld0", instr_valid, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            chk("t1_re", imem_read_enable, 4'b0001);
            chk("t1_ipc", ln(imem_pc, 0), k);
            chk("t1_vld", instr_valid, 4'b0001);
            chk("t1_ipco", ln(instr_pc, 0), k - 1);
            chk("t1_ins", ln(instr, 0), BASE + k - 1);
        end

        // ---- 2: all lanes streaming ----
        do_reset();
        start = 4'b1111;
        @(negedge clk) start = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk("t2_vld", instr_valid, 4'b1111);
            for (int i = 0; i < N; i++) begin
                chk("t2_pc", ln(instr_pc, i), k);
                chk("t2_ins", ln(instr, i), BASE + k);
            end
        end

        // ---- 3: lane 1 backpressure at pc 5 ----
        do_reset();
        start = 4'b0010;
        @(negedge clk) start = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("t3_pc", ln(instr_pc, 1), k);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk) instr_ready[1] = 1'b0;
            #1;
            chk("t3_hvld", instr_valid[1], 1);
            chk("t3_hpc", ln(instr_pc, 1), 5);
            if (c > 0) chk("t3_nore", imem_read_enable[1], 0);
        end
        @(negedge clk) instr_ready[1] = 1'b1;
        #1;
        chk("t3_drain_pc", ln(instr_pc, 1), 5);
        chk("t3_drain_ins", ln(instr, 1), BASE + 5);
        chk("t3_drain_re", imem_read_enable[1], 0);
        @(negedge clk); #1;
        chk("t3_gap_vld", instr_valid[1], 0);
        chk("t3_re6", imem_read_enable[1], 1);
        chk("t3_ipc6", ln(imem_pc, 1), 6);
        @(negedge clk); #1;
        chk("t3_vld6", instr_valid[1], 1);
        chk("t3_pc6", ln(instr_pc, 1), 6);
        chk("t3_ins6", ln(instr, 1), BASE + 6);

        // ---- 4: lane 2 redirect with word 3 in flight ----
        do_reset();
        start = 4'b0100;
        @(negedge clk) start = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("t4_pc", ln(instr_pc, 2), k);
        end
        @(negedge clk);
        redirect_valid[2] = 1'b1; redirect_pc[2*W +: W] = 32'h40;
        #1;
        chk("t4_rvld", instr_valid[2], 0);
        chk("t4_rre", imem_read_enable[2], 0);
        @(negedge clk) redirect_valid[2] = 1'b0;
        #1;
        chk("t4_vld_sq", instr_valid[2], 0);
        chk("t4_re40", imem_read_enable[2], 1);
        chk("t4_ipc40", ln(imem_pc, 2), 32'h40);
        @(negedge clk); #1;
        chk("t4_vld40", instr_valid[2], 1);
        chk("t4_pc40", ln(instr_pc, 2), 32'h40);
        chk("t4_ins40", ln(instr, 2), BASE + 32'h40);
        @(negedge clk); #1;
        chk("t4_pc41", ln(instr_pc, 2), 32'h41);

        // ---- 5: lane 3 runs off the end of memory ----
        do_reset();
        start = 4'b1000;
        @(negedge clk) start = '0;
        @(negedge clk);
        @(negedge clk);
        redirect_valid[3] = 1'b1; redirect_pc[3*W +: W] = 32'hFE;
        #1 chk("t5_rvld", instr_valid[3], 0);
        @(negedge clk) redirect_valid[3] = 1'b0;
        #1;
        chk("t5_reFE", imem_read_enable[3], 1);
        chk("t5_ipcFE", ln(imem_pc, 3), 32'hFE);
        @(negedge clk); #1;
        chk("t5_pcFE", ln(instr_pc, 3), 32'hFE);
        chk("t5_ipcFF", ln(imem_pc, 3), 32'hFF);
        @(negedge clk); #1;
        chk("t5_pcFF", ln(instr_pc, 3), 32'hFF);
        chk("t5_insFF", ln(instr, 3), BASE + 32'hFF);
        chk("t5_no100", imem_read_enable[3], 0);
        chk("t5_flt_pre", fetch_fault[3], 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("t5_flt", fetch_fault[3], 1);
            chk("t5_run", running[3], 0);
            chk("t5_re", imem_read_enable[3], 0);
            chk("t5_vld", instr_valid[3], 0);
        end
        @(negedge clk) start[3] = 1'b1;
        @(negedge clk) start[3] = 1'b0;
        #1;
        chk("t5_flt_clr", fetch_fault[3], 0);
        chk("t5_rerun", running[3], 1);
        chk("t5_re0", imem_read_enable[3], 1);
        chk("t5_ipc0", ln(imem_pc, 3), 0);

        // ---- 6: halt with hold valid, then reset mid-stream ----
        do_reset();
        start = 4'b0001;
        @(negedge clk) start = '0;
        @(negedge clk);
        @(negedge clk) instr_ready[0] = 1'b0;
        #1 chk("t6_pc1", ln(instr_pc, 0), 1);
        @(negedge clk); #1;
        chk("t6_hold", instr_valid[0], 1);
        chk("t6_hpc", ln(instr_pc, 0), 1);
        @(negedge clk) halt_req[0] = 1'b1;
        #1;
        chk("t6_hvld", instr_valid[0], 0);
        chk("t6_hre", imem_read_enable[0], 0);
        @(negedge clk) begin halt_req[0] = 1'b0; instr_ready[0] = 1'b1; end
        #1;
        chk("t6_run", running[0], 0);
        chk("t6_vld", instr_valid[0], 0);
        chk("t6_re", imem_read_enable[0], 0);
        @(negedge clk) start = 4'b1111;
        @(negedge clk) start = '0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        #1 chk("t6_busy", instr_valid, 4'b1111);
        @(negedge clk) rst = 1'b0;
        #1 chk_idle_outputs("t6_rst");
        @(negedge clk);
        #1 chk_idle_outputs("t6_idle");

        // ---- 7: randomized traffic against a program-order model ----
        do_reset();
        for (int i = 0; i < N; i++) begin
            mrun[i] = 0; exp_pc[i] = 0; ndel[i] = 0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                rv[i] = 0; hr[i] = 0; st[i] = 0; rpc[i] = 0;
                instr_ready[i] = ($urandom % 4) != 0;
                if (mrun[i]) begin
                    if (exp_pc[i] > 200 || ($urandom % 20) == 0) begin
                        rv[i] = 1; rpc[i] = $urandom % 128;
                    end else if (($urandom % 64) == 0) begin
                        hr[i] = 1;
                    end
                end else begin
                    st[i] = ($urandom % 4) == 0;
                end
                redirect_valid[i] = rv[i];
                redirect_pc[i*W +: W] = rpc[i];
                halt_req[i] = hr[i];
                start[i] = st[i];
            end
            #1;
            for (int i = 0; i < N; i++) begin
                chk("r_run", running[i], mrun[i]);
                if (imem_read_enable[i]) begin
                    chk("r_rdrng", ln(imem_pc, i) < 256, 1);
                    chk("r_rdrun", running[i], 1);
                end
                if (rv[i] || hr[i]) chk("r_flush", instr_valid[i], 0);
                if (instr_valid[i] && instr_ready[i]) begin
                    chk("r_pc", ln(instr_pc, i), exp_pc[i]);
                    chk("r_ins", ln(instr, i), BASE + exp_pc[i]);
                    exp_pc[i]++;
                    ndel[i]++;
                end
                if (hr[i]) mrun[i] = 0;
                else if (rv[i]) exp_pc[i] = int'(rpc[i]);
                if (st[i]) begin mrun[i] = 1; exp_pc[i] = 0; end
            end
        end
        for (int i = 0; i < N; i++) chk("r_progress", ndel[i] > 50, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
